// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg: shared defaults and error-flag bit positions for the L2 cache-line request arbiter.
package l2_arb_pkg;
    localparam int NSTRMS_DEF    = 64;
    localparam int MAX_OUTST_DEF = 8;
    localparam int ERR_SPUR      = 0;
    localparam int ERR_ORDER     = 1;
endpackage

// File: rtl/l2_clreq_rr_pick.sv
// l2_clreq_rr_pick: combinational round-robin picker, first candidate at or above rr_ptr+1 with wrap.
//   cand   in  nstrms     candidate request vector
//   rr_ptr in  sid_width  last granted sid
//   g_v    out 1          some candidate exists
//   g_sid  out sid_width  granted sid
// nstrms must be a power of two so sid arithmetic wraps naturally.
module l2_clreq_rr_pick
    import l2_arb_pkg::*;
#(
    parameter int nstrms    = NSTRMS_DEF,
    parameter int sid_width = $clog2(nstrms)
) (
    input  logic [nstrms-1:0]    cand,
    input  logic [sid_width-1:0] rr_ptr,
    output logic                 g_v,
    output logic [sid_width-1:0] g_sid
);
    logic [sid_width-1:0] start, off;
    logic [nstrms-1:0]    rot;

    assign start = rr_ptr + sid_width'(1);

    // rot[0] is the highest-priority position (sid start)
    always_comb begin
        rot = '0;
        for (int i = 0; i < nstrms; i++)
            rot[i] = cand[start + sid_width'(i)];
    end

    always_comb begin
        off = '0;
        for (int i = nstrms - 1; i >= 0; i--)
            if (rot[i]) off = sid_width'(i);
    end

    assign g_v   = |rot;
    assign g_sid = start + off;
endmodule

// File: rtl/l2_clreq_arb.sv
// l2_clreq_arb: round-robin merge of per-stream L2 line requests with per-stream response demux.
//   clk        in   clock
//   reset      in   asynchronous active-low reset
//   i_req_v    in   per-stream request valid       i_req_r  out  one-hot grant
//   o_req_v    out  merged request valid           o_req_r  in   L2 ready
//   o_req_sid  out  requesting stream id
//   i_rsp_v    in   L2 response valid              i_rsp_r  out  L2 response ready
//   i_rsp_sid  in   response stream id
//   o_rsp_v    out  per-stream response valid      o_rsp_r  in   per-stream response ready
//   o_outst    out  outstanding count              o_err    out  sticky {order, spurious}
// Optional: define L2_CLREQ_ORDER_CHECK_EN to check responses return in issue order.
module l2_clreq_arb
    import l2_arb_pkg::*;
#(
    parameter int nstrms    = NSTRMS_DEF,
    parameter int max_outst = MAX_OUTST_DEF,
    parameter int sid_width = $clog2(nstrms),
    parameter int cnt_width = $clog2(max_outst + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [nstrms-1:0]    i_req_v,
    output logic [nstrms-1:0]    i_req_r,
    output logic                 o_req_v,
    input  logic                 o_req_r,
    output logic [sid_width-1:0] o_req_sid,
    input  logic                 i_rsp_v,
    output logic                 i_rsp_r,
    input  logic [sid_width-1:0] i_rsp_sid,
    output logic [nstrms-1:0]    o_rsp_v,
    input  logic [nstrms-1:0]    o_rsp_r,
    output logic [cnt_width-1:0] o_outst,
    output logic [1:0]           o_err
);
    localparam logic [cnt_width-1:0] CNT_MAX = cnt_width'(max_outst);
    localparam logic [cnt_width-1:0] CNT_ONE = cnt_width'(1);
    localparam logic [nstrms-1:0]    BIT0    = nstrms'(1);

    logic [nstrms-1:0]    pend, cand;
    logic [cnt_width-1:0] cnt;
    logic [sid_width-1:0] rr_ptr, out_sid, g_sid;
    logic [1:0]           err;
    logic                 out_v, g_v, can_issue, gnt, req_acc, rsp_acc, ret, spur;
    logic                 order_err, fifo_spur;

    assign cand      = i_req_v & ~pend;
    assign can_issue = (!out_v || o_req_r) && (cnt < CNT_MAX);
    // reset gates the grant so i_req_r reads zero while reset is held
    assign gnt       = reset && can_issue && g_v;
    assign req_acc   = out_v && o_req_r;
    assign rsp_acc   = i_rsp_v && i_rsp_r;
    assign ret       = rsp_acc && pend[i_rsp_sid];
    assign spur      = (rsp_acc && !pend[i_rsp_sid]) || fifo_spur;

    l2_clreq_rr_pick #(.nstrms(nstrms), .sid_width(sid_width)) u_pick (
        .cand  (cand),
        .rr_ptr(rr_ptr),
        .g_v   (g_v),
        .g_sid (g_sid)
    );

    assign i_req_r   = gnt ? BIT0 << g_sid : '0;
    assign o_req_v   = out_v;
    assign o_req_sid = out_sid;
    assign o_rsp_v   = i_rsp_v ? BIT0 << i_rsp_sid : '0;
    assign i_rsp_r   = o_rsp_r[i_rsp_sid];
    assign o_outst   = cnt;
    assign o_err     = err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend    <= '0;
            cnt     <= '0;
            rr_ptr  <= sid_width'(nstrms - 1);
            out_v   <= 1'b0;
            out_sid <= '0;
            err     <= '0;
        end else begin
            // grant and retire never hit the same sid: pend blocks the grant
            if (gnt) pend[g_sid] <= 1'b1;
            if (ret) pend[i_rsp_sid] <= 1'b0;
            cnt <= (gnt && !ret) ? cnt + CNT_ONE : (!gnt && ret) ? cnt - CNT_ONE : cnt;
            if (gnt) begin
                out_v   <= 1'b1;
                out_sid <= g_sid;
                rr_ptr  <= g_sid;
            end else if (req_acc) begin
                out_v <= 1'b0;
            end
            err[ERR_SPUR]  <= err[ERR_SPUR] | spur;
            err[ERR_ORDER] <= err[ERR_ORDER] | order_err;
        end
    end

`ifdef L2_CLREQ_ORDER_CHECK_EN
    localparam int AW = $clog2(max_outst);

    logic [sid_width-1:0] fifo_mem [max_outst];
    logic [AW:0]          wp, rp;
    logic                 f_empty, f_full;

    assign f_empty   = wp == rp;
    assign f_full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign order_err = rsp_acc && !f_empty && (fifo_mem[rp[AW-1:0]] != i_rsp_sid);
    assign fifo_spur = rsp_acc && f_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (req_acc && !f_full) wp <= wp + (AW + 1)'(1);
            if (rsp_acc && !f_empty) rp <= rp + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk)
        if (req_acc && !f_full) fifo_mem[wp[AW-1:0]] <= out_sid;
`else
    assign order_err = 1'b0;
    assign fifo_spur = 1'b0;
`endif
endmodule

// File: tb/tb_l2_clreq_arb.sv
// tb_l2_clreq_arb: directed-vector bench for l2_clreq_arb (64 streams, 8 outstanding).
module tb_l2_clreq_arb;
    localparam int N  = 64;
    localparam int SW = 6;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  i_req_v, i_req_r, o_rsp_v, o_rsp_r;
    logic          o_req_v, o_req_r, i_rsp_v, i_rsp_r;
    logic [SW-1:0] o_req_sid, i_rsp_sid;
    logic [CW-1:0] o_outst;
    logic [1:0]    o_err;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    l2_clreq_arb dut (
        .clk      (clk),
        .reset    (reset),
        .i_req_v  (i_req_v),
        .i_req_r  (i_req_r),
        .o_req_v  (o_req_v),
        .o_req_r  (o_req_r),
        .o_req_sid(o_req_sid),
        .i_rsp_v  (i_rsp_v),
        .i_rsp_r  (i_rsp_r),
        .i_rsp_sid(i_rsp_sid),
        .o_rsp_v  (o_rsp_v),
        .o_rsp_r  (o_rsp_r),
        .o_outst  (o_outst),
        .o_err    (o_err)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] oh(input int k);
        logic [63:0] one = 64'd1;
        return one << k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_i_req_r"}, 64'(i_req_r), 64'd0);
        check({tag, "_o_req_v"}, 64'(o_req_v), 64'd0);
        check({tag, "_o_req_sid"}, 64'(o_req_sid), 64'd0);
        check({tag, "_o_outst"}, 64'(o_outst), 64'd0);
        check({tag, "_o_err"}, 64'(o_err), 64'd0);
    endtask

    task automatic do_reset(input logic [N-1:0] req_after);
        reset = 1'b0;
        settle();
        check_reset_outs("rst");
        tick();
        i_req_v = req_after;
        tick();
        reset = 1'b1;
        settle();
    endtask

    initial begin
        reset     = 1'b0;
        i_req_v   = '0;
        o_req_r   = 1'b1;
        i_rsp_v   = 1'b0;
        i_rsp_sid = '0;
        o_rsp_r   = '1;

        // streams 0, 5, 63: grant order 0, 5, 63
        do_reset(N'(oh(0) | oh(5) | oh(63)));
        check("s1_gnt0", 64'(i_req_r), oh(0));
        tick();
        check("s1_sid0", 64'(o_req_sid), 64'd0);
        check("s1_v0", 64'(o_req_v), 64'd1);
        check("s1_gnt5", 64'(i_req_r), oh(5));
        tick();
        check("s1_sid5", 64'(o_req_sid), 64'd5);
        check("s1_gnt63", 64'(i_req_r), oh(63));
        tick();
        check("s1_sid63", 64'(o_req_sid), 64'd63);
        check("s1_blocked", 64'(i_req_r), 64'd0);
        tick();
        check("s1_vdrop", 64'(o_req_v), 64'd0);
        check("s1_outst3", 64'(o_outst), 64'd3);
        check("s1_still_blocked", 64'(i_req_r), 64'd0);
        // retire stream 5 so its second request can go
        i_rsp_v   = 1'b1;
        i_rsp_sid = 6'd5;
        settle();
        check("s1_rsp_v", 64'(o_rsp_v), oh(5));
        check("s1_rsp_r", 64'(i_rsp_r), 64'd1);
        check("s1_no_gnt_on_rsp", 64'(i_req_r), 64'd0);
        tick();
        i_rsp_v = 1'b0;
        settle();
        check("s1_outst2", 64'(o_outst), 64'd2);
        check("s1_regnt5", 64'(i_req_r), oh(5));
        tick();
        check("s1_resid5", 64'(o_req_sid), 64'd5);
        check("s1_outst3b", 64'(o_outst), 64'd3);
        // asynchronous reset while a request is presented
        reset = 1'b0;
        settle();
        check_reset_outs("mid");

        // all streams request, cap at 8
        do_reset('1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("s2_gnt%0d", k), 64'(i_req_r), oh(k));
            tick();
            check($sformatf("s2_sid%0d", k), 64'(o_req_sid), 64'(k));
        end
        check("s2_outst8", 64'(o_outst), 64'd8);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("s2_capped%0d", k), 64'(i_req_r), 64'd0);
            tick();
        end
        check("s2_vdrop", 64'(o_req_v), 64'd0);
        // free a slot with sid 0: no grant this cycle, grant sid 8 next
        i_rsp_v   = 1'b1;
        i_rsp_sid = 6'd0;
        settle();
        check("s2_cap_same_cycle", 64'(i_req_r), 64'd0);
        tick();
        i_rsp_v = 1'b0;
        settle();
        check("s2_outst7", 64'(o_outst), 64'd7);
        check("s2_gnt8", 64'(i_req_r), oh(8));
        tick();
        check("s2_sid8", 64'(o_req_sid), 64'd8);
        check("s2_outst8b", 64'(o_outst), 64'd8);

        // backpressure: free a slot, hold o_req_r low for 5 cycles
        o_req_r   = 1'b0;
        i_rsp_v   = 1'b1;
        i_rsp_sid = 6'd1;
        tick();
        i_rsp_v = 1'b0;
        settle();
        check("s3_outst7", 64'(o_outst), 64'd7);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("s3_nognt%0d", k), 64'(i_req_r), 64'd0);
            check($sformatf("s3_v%0d", k), 64'(o_req_v), 64'd1);
            check($sformatf("s3_sid%0d", k), 64'(o_req_sid), 64'd8);
            tick();
        end
        o_req_r = 1'b1;
        settle();
        check("s3_gnt9", 64'(i_req_r), oh(9));
        tick();
        check("s3_sid9", 64'(o_req_sid), 64'd9);
        check("s3_outst8", 64'(o_outst), 64'd8);

        // spurious response for non-pending sid 7
        do_reset('0);
        i_rsp_v    = 1'b1;
        i_rsp_sid  = 6'd7;
        o_rsp_r[7] = 1'b0;
        settle();
        check("s4_rsp_r_lo", 64'(i_rsp_r), 64'd0);
        o_rsp_r[7] = 1'b1;
        settle();
        check("s4_rsp_v7", 64'(o_rsp_v), oh(7));
        check("s4_rsp_r_hi", 64'(i_rsp_r), 64'd1);
        tick();
        i_rsp_v = 1'b0;
        settle();
        check("s4_err0", 64'(o_err), 64'd1);
        check("s4_outst0", 64'(o_outst), 64'd0);
        tick();
        tick();
        check("s4_sticky", 64'(o_err), 64'd1);

        // issue 3 then 9, respond 9 first
        do_reset(N'(oh(3) | oh(9)));
        check("s5_gnt3", 64'(i_req_r), oh(3));
        tick();
        check("s5_gnt9", 64'(i_req_r), oh(9));
        tick();
        check("s5_sid9", 64'(o_req_sid), 64'd9);
        i_req_v = '0;
        tick();
        i_rsp_v   = 1'b1;
        i_rsp_sid = 6'd9;
        tick();
        i_rsp_v = 1'b0;
        settle();
`ifdef L2_CLREQ_ORDER_CHECK_EN
        check("s5_err_order", 64'(o_err), 64'd2);
`else
        check("s5_err_order", 64'(o_err), 64'd0);
`endif
        check("s5_outst1", 64'(o_outst), 64'd1);
        reset = 1'b0;
        settle();
        check_reset_outs("end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
